// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding and default sizing.
package spi_arb_pkg;

    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first active request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NREQ requesters: round-robin grant, start pulse,
// bounded wait for completion, single-cycle response with timeout flag.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ID_W    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                   fxclk,
    input  logic                   reset_in,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_timeout,
    output logic                   spi_tx_start,
    output logic [DATA_W-1:0]      spi_tx_data,
    input  logic                   spi_tx_end,
    input  logic [DATA_W-1:0]      spi_rx_data,
    output logic                   busy
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [CNT_W-1:0]  cnt;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gnt_id;
    logic [DATA_W-1:0] gnt_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant into an index and select that requester's word.
    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id   = ID_W'(i);
                gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Outputs are registered alongside the state; pulses default low each cycle.
    always_ff @(posedge fxclk or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            cnt          <= '0;
            req_ready    <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            spi_tx_start <= 1'b0;
            spi_tx_data  <= '0;
            busy         <= 1'b0;
        end else begin
            req_ready    <= '0;
            rsp_valid    <= 1'b0;
            spi_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready   <= grant;
                        spi_tx_data <= gnt_data;
                        cur_id      <= gnt_id;
                        rr_ptr      <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : ID_W'(gnt_id + 1'b1);
                        busy        <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    spi_tx_start <= 1'b1;
                    cnt          <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (spi_tx_end) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_data    <= spi_rx_data;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: short-timeout instance plus a default-timeout instance.
module tb_spi_txn_arbiter;

    logic        fxclk = 1'b0;
    logic        reset_in;
    logic [1:0]  req_valid;
    logic [47:0] req_data;
    logic        spi_tx_end;
    logic [23:0] spi_rx_data;

    logic [1:0]  req_ready, l_req_ready;
    logic        rsp_valid, l_rsp_valid;
    logic [0:0]  rsp_id, l_rsp_id;
    logic [23:0] rsp_data, l_rsp_data;
    logic        rsp_timeout, l_rsp_timeout;
    logic        spi_tx_start, l_spi_tx_start;
    logic [23:0] spi_tx_data, l_spi_tx_data;
    logic        busy, l_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 fxclk = ~fxclk;

    spi_txn_arbiter #(.NREQ(2), .DATA_W(24), .TIMEOUT(16), .ID_W(1)) dut (
        .fxclk(fxclk), .reset_in(reset_in), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .spi_tx_start(spi_tx_start), .spi_tx_data(spi_tx_data),
        .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data), .busy(busy)
    );

    spi_txn_arbiter dut_l (
        .fxclk(fxclk), .reset_in(reset_in), .req_valid(req_valid), .req_data(req_data),
        .req_ready(l_req_ready), .rsp_valid(l_rsp_valid), .rsp_id(l_rsp_id), .rsp_data(l_rsp_data),
        .rsp_timeout(l_rsp_timeout), .spi_tx_start(l_spi_tx_start), .spi_tx_data(l_spi_tx_data),
        .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data), .busy(l_busy)
    );

    task automatic tick();
        @(posedge fxclk);
        #1;
    endtask

    task automatic do_reset();
        reset_in    = 1'b1;
        req_valid   = '0;
        spi_tx_end  = 1'b0;
        spi_rx_data = '0;
        tick();
        tick();
        reset_in = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (req_ready === 2'b00 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 40) $display("FAIL %s_grant_wait: got no req_ready in 40 cycles, want a grant", name);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_in    = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        spi_tx_end  = 1'b0;
        spi_rx_data = '0;
        #1;
        n_checks++;
        if ({busy, req_ready, rsp_valid, rsp_id, rsp_timeout, spi_tx_start} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0", {busy, req_ready, rsp_valid, rsp_id, rsp_timeout, spi_tx_start});
        else n_pass++;
        n_checks++;
        if ({rsp_data, spi_tx_data, l_busy} !== 49'b0)
            $display("FAIL reset_data: got rsp_data=%h tx=%h l_busy=%b want 0", rsp_data, spi_tx_data, l_busy);
        else n_pass++;
        tick();
        reset_in = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_data  = {24'h000000, 24'h123456};
        req_valid = 2'b01;
        wait_ready("single");
        n_checks++;
        if (l_req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", l_req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
        n_checks++;
        if (l_spi_tx_start !== 1'b1 || l_spi_tx_data !== 24'h123456)
            $display("FAIL single_start: got start=%b data=%h want 1 123456", l_spi_tx_start, l_spi_tx_data);
        else n_pass++;
        repeat (49) tick();
        n_checks++;
        if (l_busy !== 1'b1 || l_spi_tx_data !== 24'h123456 || l_rsp_valid !== 1'b0)
            $display("FAIL single_hold: got busy=%b data=%h rsp=%b want 1 123456 0", l_busy, l_spi_tx_data, l_rsp_valid);
        else n_pass++;
        spi_rx_data = 24'hABCDEF;
        spi_tx_end  = 1'b1;
        tick();
        spi_tx_end = 1'b0;
        n_checks++;
        if ({l_rsp_valid, l_rsp_id, l_rsp_timeout, l_rsp_data} !== {1'b1, 1'b0, 1'b0, 24'hABCDEF})
            $display("FAIL single_rsp: got v=%b id=%0d to=%b data=%h want 1 0 0 abcdef",
                     l_rsp_valid, l_rsp_id, l_rsp_timeout, l_rsp_data);
        else n_pass++;
        tick();
        n_checks++;
        if (l_rsp_valid !== 1'b0 || l_rsp_data !== 24'hABCDEF || l_busy !== 1'b0)
            $display("FAIL single_after: got v=%b data=%h busy=%b want 0 abcdef 0", l_rsp_valid, l_rsp_data, l_busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [23:0] exp_d;
        logic [0:0]  exp_id;
        do_reset();
        req_data  = {24'h00BBBB, 24'h00AAAA};
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_id = t[0];
            exp_g  = exp_id[0] ? 2'b10 : 2'b01;
            exp_d  = exp_id[0] ? 24'h00BBBB : 24'h00AAAA;
            wait_ready("contention");
            n_checks++;
            if (req_ready !== exp_g) $display("FAIL contention_grant%0d: got %b want %b", t, req_ready, exp_g);
            else n_pass++;
            tick();
            n_checks++;
            if (spi_tx_start !== 1'b1 || spi_tx_data !== exp_d)
                $display("FAIL contention_start%0d: got start=%b data=%h want 1 %h", t, spi_tx_start, spi_tx_data, exp_d);
            else n_pass++;
            spi_rx_data = 24'hC0DE00 + 24'(t);
            spi_tx_end  = 1'b1;
            tick();
            spi_tx_end = 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || spi_tx_start !== 1'b0 || rsp_data !== 24'hC0DE00 + 24'(t))
                $display("FAIL contention_rsp%0d: got v=%b id=%0d start=%b data=%h want 1 %0d 0 %h",
                         t, rsp_valid, rsp_id, spi_tx_start, rsp_data, exp_id, 24'hC0DE00 + 24'(t));
            else n_pass++;
            if (t == 3) req_valid = '0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        req_data  = {24'h555555, 24'h000000};
        req_valid = 2'b10;
        wait_ready("timeout");
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL timeout_grant: got %b want 10", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
        n_checks++;
        if (spi_tx_start !== 1'b1) $display("FAIL timeout_start: got %b want 1", spi_tx_start);
        else n_pass++;
        while (rsp_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (k != 16) $display("FAIL timeout_latency: got %0d cycles want 16", k);
        else n_pass++;
        n_checks++;
        if ({rsp_timeout, rsp_id, rsp_data} !== {1'b1, 1'b1, 24'h000000})
            $display("FAIL timeout_rsp: got to=%b id=%0d data=%h want 1 1 000000", rsp_timeout, rsp_id, rsp_data);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_hold: got v=%b to=%b busy=%b want 0 1 0", rsp_valid, rsp_timeout, busy);
        else n_pass++;
    endtask

    task automatic test_simul_end();
        req_data  = {24'h000000, 24'h777777};
        req_valid = 2'b01;
        wait_ready("simul");
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL simul_grant: got %b want 01", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
        repeat (15) tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL simul_pre: got v=%b busy=%b want 0 1", rsp_valid, busy);
        else n_pass++;
        spi_rx_data = 24'h5A5A5A;
        spi_tx_end  = 1'b1;
        tick();
        spi_tx_end = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_timeout, rsp_data} !== {1'b1, 1'b0, 24'h5A5A5A})
            $display("FAIL simul_rsp: got v=%b to=%b data=%h want 1 0 5a5a5a", rsp_valid, rsp_timeout, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        req_data  = {24'h999999, 24'h111111};
        req_valid = 2'b01;
        wait_ready("rstwait");
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL rstwait_grant: got %b want 01", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
        repeat (5) tick();
        reset_in = 1'b1;
        #1;
        n_checks++;
        if ({busy, rsp_valid, rsp_timeout, rsp_id, req_ready, spi_tx_start} !== 7'b0)
            $display("FAIL rstwait_ctrl: got %b want 0", {busy, rsp_valid, rsp_timeout, rsp_id, req_ready, spi_tx_start});
        else n_pass++;
        n_checks++;
        if (spi_tx_data !== 24'h0 || rsp_data !== 24'h0)
            $display("FAIL rstwait_data: got tx=%h rsp=%h want 0 0", spi_tx_data, rsp_data);
        else n_pass++;
        tick();
        tick();
        reset_in = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL rstwait_norsp: got %0d responses want 0", seen);
        else n_pass++;
        req_valid = 2'b11;
        wait_ready("rstwait_fresh");
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL rstwait_rrptr: got %b want 01", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
        spi_rx_data = 24'h2468AC;
        spi_tx_end  = 1'b1;
        tick();
        spi_tx_end = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_timeout, rsp_data} !== {1'b1, 1'b0, 1'b0, 24'h2468AC})
            $display("FAIL rstwait_rsp: got v=%b id=%0d to=%b data=%h want 1 0 0 2468ac",
                     rsp_valid, rsp_id, rsp_timeout, rsp_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_stray_end();
        spi_rx_data = 24'hFFFFFF;
        spi_tx_end  = 1'b1;
        tick();
        spi_tx_end = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stray_rsp: got v=%b busy=%b want 0 0", rsp_valid, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 24'h2468AC || busy !== 1'b0 || spi_tx_start !== 1'b0)
            $display("FAIL stray_state: got v=%b data=%h busy=%b start=%b want 0 2468ac 0 0",
                     rsp_valid, rsp_data, busy, spi_tx_start);
        else n_pass++;
        req_valid = 2'b11;
        wait_ready("stray");
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL stray_grant: got %b want 10", req_ready);
        else n_pass++;
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_simul_end();
        test_reset_wait();
        test_stray_end();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing the SPI master (2..8).
REQ-002 Parameter DATA_W, default 24, SPI transaction word width.
REQ-003 Parameter TIMEOUT, default 4096, fxclk cycles allowed between spi_tx_start and spi_tx_end.
REQ-004 Parameter ID_W, default 1, requester index width; SHALL equal max(1, clog2(NREQ)).
REQ-005 fxclk  in  1  sole clock; all logic on rising edge.
REQ-006 reset_in  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NREQ  per-requester transaction request, held until accepted.
REQ-008 req_data  in  NREQ*DATA_W  per-requester TX word; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  out  NREQ  one-hot acceptance pulse, one cycle.
REQ-010 rsp_valid  out  1  response pulse, one cycle, no backpressure.
REQ-011 rsp_id  out  ID_W  index of requester owning the response.
REQ-012 rsp_data  out  DATA_W  captured RX word.
REQ-013 rsp_timeout  out  1  qualifies rsp_valid; transaction timed out.
REQ-014 spi_tx_start  out  1  start pulse to SPI master.
REQ-015 spi_tx_data  out  DATA_W  TX word to SPI master, stable from spi_tx_start until response.
REQ-016 spi_tx_end  in  1  SPI master completion pulse.
REQ-017 spi_rx_data  in  DATA_W  RX word, valid when spi_tx_end is high.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-020 IDLE: when any req_valid bit is set, grant exactly one requester, pulse its req_ready, latch its req_data into spi_tx_data and its index, go to START; otherwise stay.
REQ-021 Arbitration SHALL be round-robin: search starts at index rr_ptr, wrapping NREQ-1 -> 0; after a grant to i, rr_ptr becomes (i+1) mod NREQ.
REQ-022 START: spi_tx_start high for exactly this cycle, timeout counter cleared, go to WAIT.
REQ-023 WAIT: counter increments each cycle; spi_tx_end captures spi_rx_data, sets timeout flag 0, goes to RESP.
REQ-024 WAIT: counter reaching TIMEOUT-1 without spi_tx_end sets timeout flag 1 and rsp_data 0, goes to RESP; if spi_tx_end coincides with that cycle, spi_tx_end wins (normal completion).
REQ-025 RESP: rsp_valid high for exactly this cycle with rsp_id, rsp_data, rsp_timeout; go to IDLE.
REQ-026 spi_tx_end outside WAIT SHALL be ignored, with no state or data change.
REQ-027 Latency: acceptance at cycle N -> spi_tx_start at N+1; spi_tx_end at cycle M -> rsp_valid at M+1; next acceptance no earlier than M+2.
REQ-028 req_valid deasserting in any state other than IDLE SHALL not affect the in-flight transaction.
REQ-029 rsp_id, rsp_data and rsp_timeout SHALL hold their values until the next RESP.
REQ-030 The counter SHALL be wide enough for TIMEOUT-1 and SHALL not wrap.

Reset
REQ-031 reset_in high SHALL immediately force IDLE with rr_ptr=0, counter=0, and all outputs 0, including req_ready, rsp_*, spi_tx_start, spi_tx_data and busy.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no response issued; the first grant after release SHALL follow REQ-020.

Structure
REQ-033 The state encoding enum and default DATA_W/TIMEOUT constants SHALL live in shared package spi_arb_pkg.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arbiter (NREQ-wide, inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-035 Single requester: req_valid[0], data 24'h123456; SPI model returns 24'hABCDEF after 50 cycles -> spi_tx_data=24'h123456, rsp_valid with rsp_id=0, rsp_data=24'hABCDEF, rsp_timeout=0.
REQ-036 Contention: req_valid=2'b11 held continuously -> grants alternate 0,1,0,1 over four transactions, each with one spi_tx_start.
REQ-037 Timeout: SPI model never pulses spi_tx_end, TIMEOUT=16 -> rsp_valid exactly 16 cycles after spi_tx_start, rsp_timeout=1, rsp_data=0.
REQ-038 Simultaneous end/timeout: spi_tx_end on the cycle the counter reaches TIMEOUT-1 -> rsp_timeout=0, rsp_data=spi_rx_data.
REQ-039 Reset during WAIT: no rsp_valid; busy=0 and all outputs 0 immediately; a fresh request then completes normally with rsp_id from rr_ptr=0.
REQ-040 Stray spi_tx_end in IDLE -> no rsp_valid and no state change.
